// File: rtl/screen_text_ctrl.sv
// screen_text_ctrl: text-mode screen controller sharing one RAM port between the
// display read path and a small command engine (put char, set cursor, clear).
//
// Handshake: a command transfers on a rising edge where req_valid && req_ready;
// req_ready is high only while idle and out of reset, and the requester must hold
// req_cmd/req_char/req_row/req_col stable while req_valid is high.
module screen_text_ctrl #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [7:0]  req_char,
  input  logic [4:0]  req_row,
  input  logic [6:0]  req_col,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] ROWS_LIM = 6'(ROWS);
  localparam logic [7:0] COLS_LIM = 8'(COLS);

  localparam logic [1:0] CMD_PUT   = 2'b00;
  localparam logic [1:0] CMD_SET   = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUT   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic [6:0]  cur_col_q, cur_col_d;
  logic [4:0]  sweep_row_q, sweep_row_d;
  logic [6:0]  sweep_col_q, sweep_col_d;
  logic [7:0]  char_q, char_d;
  logic        err_q, err_d;
  logic        accept;
  logic        write;
  logic [11:0] write_addr;
  logic [7:0]  write_data;
  logic [11:0] pixel_addr;

  // Row-major successor of (r, c) inside the visible window, wrapping to (0,0).
  function automatic logic [11:0] advance(input logic [4:0] r, input logic [6:0] c);
    if (c == LAST_COL) begin
      if (r == LAST_ROW) return 12'd0;
      return {r + 5'd1, 7'd0};
    end
    return {r, c + 7'd1};
  endfunction

  assign pixel_addr = {y[8:4], x[9:3]};
  assign req_ready  = (state_q == IDLE) && !reset;
  assign busy       = (state_q != IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;
  assign cmd_err    = err_q;

  // Next-state, cursor/sweep update and write request; writes only in blanking.
  always_comb begin
    state_d     = state_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    sweep_row_d = sweep_row_q;
    sweep_col_d = sweep_col_q;
    char_d      = char_q;
    err_d       = 1'b0;
    write       = 1'b0;
    write_addr  = 12'd0;
    write_data  = 8'd0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (req_cmd)
            CMD_PUT: begin
              char_d  = req_char;
              state_d = PUT;
            end
            CMD_SET: begin
              if (({1'b0, req_row} < ROWS_LIM) && ({1'b0, req_col} < COLS_LIM)) begin
                cur_row_d = req_row;
                cur_col_d = req_col;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_CLEAR: begin
              sweep_row_d = 5'd0;
              sweep_col_d = 7'd0;
              state_d     = CLEAR;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      PUT: begin
        if (!video_on) begin
          write                  = 1'b1;
          write_addr             = {cur_row_q, cur_col_q};
          write_data             = char_q;
          {cur_row_d, cur_col_d} = advance(cur_row_q, cur_col_q);
          state_d                = IDLE;
        end
      end
      CLEAR: begin
        if (!video_on) begin
          write      = 1'b1;
          write_addr = {sweep_row_q, sweep_col_q};
          write_data = BLANK_CHAR;
          if ((sweep_row_q == LAST_ROW) && (sweep_col_q == LAST_COL)) begin
            cur_row_d   = 5'd0;
            cur_col_d   = 7'd0;
            sweep_row_d = 5'd0;
            sweep_col_d = 7'd0;
            state_d     = IDLE;
          end else begin
            {sweep_row_d, sweep_col_d} = advance(sweep_row_q, sweep_col_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port mux: display address unless a write is actually being issued.
  always_comb begin
    ram_we    = write && !reset;
    ram_addr  = ram_we ? write_addr : pixel_addr;
    ram_wdata = ram_we ? write_data : 8'd0;
  end

  // State, cursor, sweep, latched character and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_row_q   <= 5'd0;
      cur_col_q   <= 7'd0;
      sweep_row_q <= 5'd0;
      sweep_col_q <= 7'd0;
      char_q      <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      sweep_row_q <= sweep_row_d;
      sweep_col_q <= sweep_col_d;
      char_q      <= char_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_screen_text_ctrl.sv
// tb_screen_text_ctrl: randomized bench for screen_text_ctrl with a screen-level
// reference model (cursor as a linear position, expected writes in a queue).
module tb_screen_text_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0;
  logic [9:0]  x = 10'd0;
  logic [9:0]  y = 10'd0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = 2'b00;
  logic [7:0]  req_char = 8'h00;
  logic [4:0]  req_row = 5'd0;
  logic [6:0]  req_col = 7'd0;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;
  logic        cmd_err;

  screen_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_char(req_char), .req_row(req_row), .req_col(req_col),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .cmd_err(cmd_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];   // {addr[11:0], data[7:0]}
  int checks = 0;
  int failures = 0;
  int mrow = 0;
  int mcol = 0;
  int exp_err = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int vmode = 0;           // 0: blanking, 1: random 50%, 2: active display

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_apply(input logic [1:0] cmd, input logic [7:0] ch,
                             input logic [4:0] r, input logic [6:0] c);
    int lin;
    case (cmd)
      2'b00: begin
        exp_q.push_back({5'(mrow), 7'(mcol), ch});
        lin = (mrow * COLS + mcol + 1) % CELLS;
        mrow = lin / COLS;
        mcol = lin % COLS;
      end
      2'b01: begin
        if (int'(r) < ROWS && int'(c) < COLS) begin
          mrow = int'(r);
          mcol = int'(c);
        end else begin
          exp_err++;
        end
      end
      2'b10: begin
        for (int rr = 0; rr < ROWS; rr++)
          for (int cc = 0; cc < COLS; cc++)
            exp_q.push_back({5'(rr), 7'(cc), 8'h20});
        mrow = 0;
        mcol = 0;
      end
      default: exp_err++;
    endcase
  endtask

  // ---------------- input drivers ----------------
  // Video timing stand-in: new pixel position and video_on each cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (vmode)
        0: video_on = 1'b0;
        1: video_on = 1'($urandom_range(0, 1));
        default: video_on = 1'b1;
      endcase
      x = 10'($urandom_range(0, 1023));
      y = 10'($urandom_range(0, 1023));
    end
  end

  task automatic do_cmd(input logic [1:0] cmd, input logic [7:0] ch,
                        input logic [4:0] r, input logic [6:0] c);
    int n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_char  = ch;
    req_row   = r;
    req_col   = c;
    model_apply(cmd, ch, r, c);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic verify_state(input string tag);
    @(negedge clk); #1;
    check_val({tag, "_row"}, 32'(cur_row), 32'(mrow));
    check_val({tag, "_col"}, 32'(cur_col), 32'(mcol));
    check_val({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [19:0] e;
    if (reset) begin
      check_val("rst_we", 32'(ram_we), 32'd0);
      check_val("rst_ready", 32'(req_ready), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
    end else begin
      if (busy) busy_cnt++;
      if (cmd_err) err_cnt++;
      if (video_on) check_val("active_we", 32'(ram_we), 32'd0);
      if (ram_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", {20'd0, ram_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("wr_addr", 32'(ram_addr), 32'(e[19:8]));
          check_val("wr_data", 32'(ram_wdata), 32'(e[7:0]));
        end
      end else begin
        check_val("rd_addr", 32'(ram_addr), 32'({y[8:4], x[9:3]}));
        check_val("rd_wdata", 32'(ram_wdata), 32'd0);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int wr0;
    int n;
    logic [1:0] cmd;
    logic [4:0] r;
    logic [6:0] c;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check_val("reset_row", 32'(cur_row), 32'd0);
    check_val("reset_col", 32'(cur_col), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_ready", 32'(req_ready), 32'd1);
    check_val("reset_err", 32'(cmd_err), 32'd0);

    // Single put in blanking: one write, busy for one cycle.
    vmode = 0;
    busy_cnt = 0;
    wr0 = wr_cnt;
    do_cmd(2'b00, 8'h41, 5'd0, 7'd0);
    wait_idle(50);
    verify_state("put_a");
    check_val("put_a_writes", 32'(wr_cnt - wr0), 32'd1);
    check_val("put_a_busy", 32'(busy_cnt), 32'd1);

    // Last cell then wrap to origin.
    do_cmd(2'b01, 8'h00, 5'd29, 7'd79);
    wait_idle(50);
    verify_state("set_last");
    do_cmd(2'b00, 8'h33, 5'd0, 7'd0);
    wait_idle(50);
    verify_state("put_wrap");

    // Rejected commands.
    wr0 = wr_cnt;
    do_cmd(2'b01, 8'h00, 5'd3, 7'd7);
    wait_idle(50);
    do_cmd(2'b01, 8'h00, 5'd30, 7'd0);
    wait_idle(50);
    verify_state("set_bad_row");
    do_cmd(2'b01, 8'h00, 5'd0, 7'd80);
    wait_idle(50);
    verify_state("set_bad_col");
    do_cmd(2'b11, 8'h00, 5'd0, 7'd0);
    wait_idle(50);
    verify_state("reserved");
    check_val("err_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Put held off by active display for 10 cycles.
    vmode = 2;
    @(posedge clk);
    wr0 = wr_cnt;
    do_cmd(2'b00, 8'h5A, 5'd0, 7'd0);
    repeat (10) @(posedge clk);
    #1;
    check_val("stall_busy", 32'(busy), 32'd1);
    check_val("stall_no_write", 32'(wr_cnt - wr0), 32'd0);
    vmode = 0;
    wait_idle(50);
    verify_state("stall_put");
    check_val("stall_writes", 32'(wr_cnt - wr0), 32'd1);

    // Clear without stalls.
    busy_cnt = 0;
    wr0 = wr_cnt;
    do_cmd(2'b10, 8'h00, 5'd0, 7'd0);
    wait_idle(CELLS + 100);
    verify_state("clear_fast");
    check_val("clear_fast_writes", 32'(wr_cnt - wr0), 32'(CELLS));
    check_val("clear_fast_cycles", 32'(busy_cnt), 32'(CELLS));

    // Clear with video_on toggling.
    do_cmd(2'b01, 8'h00, 5'd12, 7'd40);
    wait_idle(50);
    vmode = 1;
    busy_cnt = 0;
    wr0 = wr_cnt;
    do_cmd(2'b10, 8'h00, 5'd0, 7'd0);
    wait_idle(8 * CELLS);
    verify_state("clear_slow");
    check_val("clear_slow_writes", 32'(wr_cnt - wr0), 32'(CELLS));
    check_val("clear_slow_stalled", 32'(busy_cnt > CELLS), 32'd1);

    // Randomized command mix.
    for (int i = 0; i < 40; i++) begin
      vmode = $urandom_range(0, 1);
      if ($urandom_range(0, 11) == 0) cmd = 2'b10;
      else begin
        n = $urandom_range(0, 9);
        cmd = (n < 5) ? 2'b00 : (n < 9) ? 2'b01 : 2'b11;
      end
      r = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, ROWS - 1));
      c = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, COLS - 1));
      do_cmd(cmd, 8'($urandom_range(0, 255)), r, c);
      wait_idle(8 * CELLS);
      verify_state("rand");
    end

    // Reset part-way through a clear.
    vmode = 0;
    do_cmd(2'b01, 8'h00, 5'd7, 7'd9);
    wait_idle(50);
    wr0 = wr_cnt;
    do_cmd(2'b10, 8'h00, 5'd0, 7'd0);
    n = 0;
    while ((wr_cnt - wr0) < 100 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    reset = 1'b1;
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("abort_writes", 32'(wr_cnt - wr0), 32'd100);
    check_val("abort_busy", 32'(busy), 32'd0);
    verify_state("abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_text_ctrl.md
SCREEN_TEXT_CTRL -- requirements
Module: screen_text_ctrl

Interface
REQ-001 Parameters SHALL be: COLS, default 80, visible text columns; ROWS, default 30, visible text rows; BLANK_CHAR, default 8'h20, fill code for clear.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all logic rising-edge.
  reset  in  1  synchronous, active-high.
  video_on  in  1  active display region flag.
  x  in  10  current pixel column.
  y  in  10  current pixel row.
  req_valid  in  1  command request.
  req_ready  out  1  controller accepts a command this cycle.
  req_cmd  in  2  00 put char at cursor, 01 set cursor, 10 clear screen, 11 reserved.
  req_char  in  8  ASCII code for put-char.
  req_row  in  5  target row for set-cursor.
  req_col  in  7  target column for set-cursor.
  ram_addr  out  12  screen RAM address {row[4:0], col[6:0]}.
  ram_we  out  1  screen RAM write enable.
  ram_wdata  out  8  screen RAM write data.
  cur_row  out  5  cursor row.
  cur_col  out  7  cursor column.
  busy  out  1  high whenever state is not IDLE.
  cmd_err  out  1  one-cycle pulse on a rejected command.

Function
REQ-003 The screen RAM port SHALL be shared: display read owns it while video_on=1; controller writes happen only while video_on=0.
REQ-004 When video_on=1, ram_addr SHALL equal {y[8:4], x[9:3]} combinationally and ram_we SHALL be 0.
REQ-005 States SHALL be IDLE, PUT, CLEAR.
REQ-006 req_ready SHALL be 1 only in IDLE and not in reset; a command is accepted when req_valid and req_ready are both 1.
REQ-007 Accepted put-char (00): latch req_char, go to PUT next cycle.
REQ-008 In PUT with video_on=0: ram_we=1, ram_addr={cur_row,cur_col}, ram_wdata=latched char for exactly one cycle. On the next edge advance the cursor and return to IDLE.
REQ-009 In PUT with video_on=1: hold state and latched char; no write.
REQ-010 Cursor advance: col+1. At col=COLS-1, wrap to col=0 and row+1. At row=ROWS-1 and col=COLS-1, wrap to row=0, col=0.
REQ-011 Accepted set-cursor (01) with req_row<ROWS and req_col<COLS: update cursor on the next edge, stay in IDLE, no RAM write.
REQ-012 Set-cursor out of range: cursor unchanged, cmd_err=1 for the following cycle.
REQ-013 Reserved command (11): no action, cmd_err=1 for the following cycle.
REQ-014 Accepted clear (10): initialise sweep counters to row 0, col 0 and enter CLEAR.
REQ-015 In CLEAR, each cycle with video_on=0: write BLANK_CHAR at {sweep_row, sweep_col}, then advance the sweep in the same order as REQ-010.
REQ-016 In CLEAR, cycles with video_on=1 stall the sweep with no write.
REQ-017 The CLEAR write at (ROWS-1, COLS-1) SHALL be the last; next edge: cursor=(0,0), state=IDLE. A clear with no stalls takes exactly ROWS*COLS write cycles.
REQ-018 Columns COLS..127 and rows ROWS..31 SHALL never be written.
REQ-019 When not writing and video_on=0, ram_addr SHALL still be {y[8:4], x[9:3]} and ram_wdata SHALL be 0.
REQ-020 video_on falling mid-command: the write happens on the first blanking cycle. video_on rising: a write issued in the current cycle completes; the next cycle stalls.

Reset
REQ-021 With reset=1 on a clk edge: state=IDLE, cursor=(0,0), sweep counters=0, latched char=0, cmd_err=0.
REQ-022 While reset=1: req_ready=0, ram_we=0, busy=0.
REQ-023 Reset SHALL abort any PUT or CLEAR in progress with no further writes; partially cleared RAM contents are left as is.

Verification
REQ-024 Put-char sequence: video_on=0, put 8'h41 -> exactly one write {0,0}<=8'h41, cursor (0,1), busy high 1 cycle.
REQ-025 Cursor wrap: set (29,79), then put 8'h33 -> write addr {5'd29,7'd79}, then cursor (0,0).
REQ-026 Error cases: set (30,0) -> cmd_err pulse, cursor unchanged, no write; cmd 11 -> cmd_err pulse.
REQ-027 Stalled put: video_on=1 for 10 cycles after a put is accepted -> ram_we=0 and ram_addr tracks {y[8:4],x[9:3]}; write occurs on first video_on=0 cycle.
REQ-028 Clear: video_on=0 throughout -> 2400 writes of 8'h20, row-major, no address with col>=80; then idle with cursor (0,0). Repeat with video_on toggling 50% -> same write set, more cycles.
REQ-029 Mid-clear abort: reset asserted after 100 clear writes -> no write in any later cycle, state IDLE, cursor (0,0).
